// File: rtl/manchester_tx_serial.sv
// Serial Manchester transmitter: valid/ready word in, framed Manchester line out
// (optional preamble, data, and a parity symbol when MANCH_PARITY_EN is defined).
module manchester_tx_serial #(
    parameter int DATA_W   = 8,
    parameter int HALF_CYC = 1,
    parameter int PRE_BITS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic              msb_first,
    output logic              tx_out,
    output logic              tx_en,
    output logic              busy,
    output logic              done
);
    // Handshake: a word is taken on a rising edge where in_valid && in_ready;
    // in_valid while in_ready is low is ignored and nothing is queued.

    localparam int HC_W    = $clog2(HALF_CYC) + 1;
    localparam int BIT_MAX = (PRE_BITS > DATA_W + 1) ? PRE_BITS : DATA_W + 1;
    localparam int BC_W    = $clog2(BIT_MAX);

    localparam logic [HC_W-1:0] HC_LAST   = HC_W'(HALF_CYC - 1);
    localparam logic [BC_W-1:0] PRE_LAST  = BC_W'((PRE_BITS > 0) ? PRE_BITS - 1 : 0);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA
`ifdef MANCH_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic              mode_r;
    logic              msb_r;
    logic [HC_W-1:0]   half_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic              second;
`ifdef MANCH_PARITY_EN
    logic              parity_r;
`endif

    logic first_in;
    logic start_bit;
    logic data_head;
    logic data_next;

    // First half of a symbol: IEEE sends ~b then b, Thomas sends b then ~b.
    function automatic logic first_half(input logic m, input logic b);
        return m ? b : ~b;
    endfunction

    assign first_in  = msb_first ? in_data[DATA_W-1] : in_data[0];
    assign start_bit = (PRE_BITS > 0) ? 1'b1 : first_in;
    assign data_head = msb_r ? shreg[DATA_W-1] : shreg[0];
    assign data_next = msb_r ? shreg[DATA_W-2] : shreg[1];

    assign in_ready = (state == IDLE) && ena;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            mode_r   <= 1'b0;
            msb_r    <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            second   <= 1'b0;
            tx_out   <= 1'b0;
            tx_en    <= 1'b0;
            done     <= 1'b0;
`ifdef MANCH_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else if (ena) begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    shreg    <= in_data;
                    mode_r   <= mode;
                    msb_r    <= msb_first;
`ifdef MANCH_PARITY_EN
                    parity_r <= ^in_data;
`endif
                    if (PRE_BITS > 0) state <= PRE;
                    else              state <= DATA;
                    tx_out   <= first_half(mode, start_bit);
                    tx_en    <= 1'b1;
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    second   <= 1'b0;
                end
            end else if (half_cnt != HC_LAST) begin
                half_cnt <= half_cnt + HC_W'(1);
            end else begin
                half_cnt <= '0;
                if (!second) begin
                    second <= 1'b1;
                    tx_out <= ~tx_out;
                end else begin
                    // Symbol boundary: load the first half of the next bit or close the frame.
                    second <= 1'b0;
                    case (state)
                        PRE: begin
                            if (bit_cnt == PRE_LAST) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                tx_out  <= first_half(mode_r, data_head);
                            end else begin
                                bit_cnt <= bit_cnt + BC_W'(1);
                                tx_out  <= first_half(mode_r, bit_cnt[0]);
                            end
                        end
                        DATA: begin
                            if (msb_r) shreg <= {shreg[DATA_W-2:0], 1'b0};
                            else       shreg <= {1'b0, shreg[DATA_W-1:1]};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
`ifdef MANCH_PARITY_EN
                                state   <= PAR;
                                tx_out  <= first_half(mode_r, parity_r);
`else
                                state   <= IDLE;
                                tx_out  <= 1'b0;
                                tx_en   <= 1'b0;
                                done    <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BC_W'(1);
                                tx_out  <= first_half(mode_r, data_next);
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            tx_out  <= 1'b0;
                            tx_en   <= 1'b0;
                            done    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_manchester_tx_serial.sv
// Bench for manchester_tx_serial: two instances (HALF_CYC=1/PRE_BITS=0 and
// HALF_CYC=2/PRE_BITS=2) checked every cycle against a frame-level waveform model.
module tb_manchester_tx_serial;
    localparam int DW = 8;
`ifdef MANCH_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] in_data   [2];
    logic          in_valid  [2];
    logic          ena       [2];
    logic          mode      [2];
    logic          msb_first [2];
    logic          in_ready  [2];
    logic          tx_out    [2];
    logic          tx_en     [2];
    logic          busy      [2];
    logic          done      [2];

    int n_vec = 0;
    int n_err = 0;
    int q_len [2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int HC = (g == 0) ? 1 : 2;
        localparam int PB = (g == 0) ? 0 : 2;

        manchester_tx_serial #(.DATA_W(DW), .HALF_CYC(HC), .PRE_BITS(PB)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena       (ena[g]),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .mode      (mode[g]),
            .msb_first (msb_first[g]),
            .tx_out    (tx_out[g]),
            .tx_en     (tx_en[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );

        // Expected per-cycle {done, tx_en, tx_out}; one entry per enabled clock.
        logic [2:0]    exp_q[$];
        logic [2:0]    cur = 3'b000;
        logic          edge_en = 1'b0;
        logic          acc = 1'b0;
        logic [DW-1:0] acc_data;
        logic          acc_mode;
        logic          acc_msb;

        always @(posedge clk) begin
            edge_en  = rst_n && ena[g];
            acc      = rst_n && ena[g] && in_valid[g] && (exp_q.size() == 0);
            acc_data = in_data[g];
            acc_mode = mode[g];
            acc_msb  = msb_first[g];
        end

        always @(negedge clk) begin : mon
            int   nb;
            int   k;
            logic b;
            logic h;
            if (!rst_n) begin
                exp_q.delete();
                cur = 3'b000;
            end else begin
                if (acc) begin
                    nb = PB + DW + PAR;
                    for (int i = 0; i < nb; i++) begin
                        if (i < PB) begin
                            b = ~i[0];
                        end else if (i < PB + DW) begin
                            k = i - PB;
                            b = acc_msb ? acc_data[DW-1-k] : acc_data[k];
                        end else begin
                            b = ^acc_data;
                        end
                        h = acc_mode ? b : ~b;
                        repeat (HC) exp_q.push_back({2'b01, h});
                        repeat (HC) exp_q.push_back({2'b01, ~h});
                    end
                    exp_q.push_back(3'b100);
                end
                if (edge_en) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            end
            q_len[g] = exp_q.size();
            check($sformatf("i%0d.tx_out", g), 32'(tx_out[g]), 32'(cur[0]));
            check($sformatf("i%0d.tx_en", g), 32'(tx_en[g]), 32'(cur[1]));
            check($sformatf("i%0d.busy", g), 32'(busy[g]), 32'(cur[1]));
            check($sformatf("i%0d.done", g), 32'(done[g]), 32'(cur[2]));
            check($sformatf("i%0d.in_ready", g), 32'(in_ready[g]), 32'(ena[g] && !cur[1]));
        end
    end

    task automatic send(input int sel, input logic [DW-1:0] d, input logic m,
                        input logic msb, input bit keep);
        int t;
        @(posedge clk); #1;
        in_data[sel]   = d;
        mode[sel]      = m;
        msb_first[sel] = msb;
        in_valid[sel]  = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready[sel]) break;
            t++;
            if (t > 500) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        if (!keep) in_valid[sel] = 1'b0;
    endtask

    task automatic wait_idle(input int sel, input bit glitch);
        int t;
        t = 0;
        while (q_len[sel] != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
            if (glitch && $urandom_range(0, 7) == 0) begin
                ena[sel] = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 ena[sel] = 1'b1;
            end
        end
        if (t >= 3000) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic capture(input logic [DW-1:0] d, input logic m, input logic msb,
                           input int n, output logic [31:0] w);
        send(0, d, m, msb, 1'b0);
        w = '0;
        repeat (n) begin
            @(negedge clk);
            w = {w[30:0], tx_out[0]};
        end
        wait_idle(0, 1'b0);
    endtask

    initial begin
        #500000;
        check("watchdog", 32'd0, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [31:0] w;
        int          cnt;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data[i] = '0; in_valid[i] = 1'b0; ena[i] = 1'b1;
            mode[i] = 1'b0; msb_first[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_out", 32'(tx_out[0]), 32'd0);
        check("rst_tx_en", 32'(tx_en[1]), 32'd0);
        check("rst_busy", 32'(busy[1]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        rst_n = 1'b1;

        // Literal waveforms, HALF_CYC=1, no preamble.
        capture(8'hB2, 1'b0, 1'b1, 16, w); check("wave_b2_ieee", w, 32'h65A6);
        capture(8'hB2, 1'b1, 1'b1, 16, w); check("wave_b2_thomas", w, 32'h9A59);
        capture(8'hF0, 1'b0, 1'b1, 16, w); check("wave_f0_ieee", w, 32'h55AA);
        capture(8'hF0, 1'b1, 1'b1, 16, w); check("wave_f0_thomas", w, 32'hAA55);
`ifdef MANCH_PARITY_EN
        capture(8'h07, 1'b0, 1'b1, 18, w); check("par_07", w & 32'h3, 32'h1);
        capture(8'hB2, 1'b0, 1'b1, 18, w); check("par_b2", w & 32'h3, 32'h2);
`endif

        // Preamble, HALF_CYC=2, LSB first: count tx_en cycles.
        send(1, 8'h0F, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        do begin
            @(negedge clk);
            if (tx_en[1]) cnt++;
        end while (tx_en[1] && cnt < 200);
        check("tx_en_len", 32'(cnt), 32'((2 + DW + PAR) * 2 * 2));
        wait_idle(1, 1'b0);

        // Back-to-back with in_valid held high.
        send(0, 8'hB2, 1'b0, 1'b1, 1'b1);
        send(0, 8'hF0, 1'b0, 1'b1, 1'b0);
        wait_idle(0, 1'b0);

        // Five frozen cycles mid-symbol delay done by exactly five cycles.
        send(1, 8'h5C, 1'b1, 1'b1, 1'b0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 7)  ena[1] = 1'b0;
            if (cnt == 12) ena[1] = 1'b1;
        end while (!done[1] && cnt < 200);
        check("ena_freeze_len", 32'(cnt), 32'((2 + DW + PAR) * 2 * 2 + 1 + 5));
        wait_idle(1, 1'b0);

        // Asynchronous reset mid-frame, then a fresh frame.
        send(1, 8'hA7, 1'b0, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_tx_out", 32'(tx_out[1]), 32'd0);
        check("arst_tx_en", 32'(tx_en[1]), 32'd0);
        check("arst_busy", 32'(busy[1]), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(1, 8'h3C, 1'b1, 1'b0, 1'b0);
        wait_idle(1, 1'b0);

        // Randomized frames with random enable drops.
        repeat (40) begin
            int sel;
            sel = $urandom_range(0, 1);
            send(sel, DW'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            wait_idle(sel, 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/manchester_tx_serial.md
Name: manchester_tx_serial

Overview:
Parametrised serial Manchester transmitter, the successor to the 8-bit parallel Manchester encoder. It accepts a DATA_W-bit word over a valid/ready handshake and emits it as a framed serial line: optional preamble, data bits, then an optional parity bit. Each bit is one Manchester symbol of 2*HALF_CYC clocks. It supports IEEE 802.3 and G.E. Thomas conventions, selectable per frame, and sits between the register/IO wrapper and the pad driving the line.

Parameters:
DATA_W, 8, payload bits per frame (>=2)
HALF_CYC, 1, clocks per half-symbol (>=1)
PRE_BITS, 0, preamble bit count, alternating pattern starting with 1 (0 = no preamble)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state and outputs
in_data  input  DATA_W  payload word
in_valid  input  1  payload valid
in_ready  output  1  block can accept; = (state==IDLE) && ena
mode  input  1  0 = IEEE (0 -> high,low; 1 -> low,high); 1 = Thomas (inverse)
msb_first  input  1  1 = transmit in_data[DATA_W-1] first; 0 = LSB first
tx_out  output  1  Manchester line
tx_en  output  1  high while a symbol is being driven
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst_n=0): state IDLE, tx_out=0, tx_en=0, busy=0, done=0, shift register and counters cleared. Reset mid-frame aborts immediately with no partial symbol completion.
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Accept: on a rising edge with in_valid && in_ready, latch in_data, mode and msb_first. Frame-local copies are used for the whole frame; input changes mid-frame have no effect. in_valid while not ready is ignored and nothing is queued.
- States: IDLE -> PRE (if PRE_BITS>0) else DATA -> PAR (MANCH_PARITY_EN only) -> IDLE.
- Latency: the first half of the first symbol appears on tx_out in the cycle after accept. tx_en=1 from that cycle through the last half of the last symbol.
- Symbol: first half for HALF_CYC clocks, second half for HALF_CYC clocks; bit b in IEEE gives halves (~b, b); Thomas gives (b, ~b).
- Preamble bit i (i=0..PRE_BITS-1) = ~i[0], i.e. 1,0,1,0..., encoded with the frame's mode.
- Frame length in cycles = (PRE_BITS + DATA_W [+1 if parity]) * 2 * HALF_CYC.
- End: the cycle after the last half completes, state=IDLE, tx_en=0, tx_out=0, busy=0, done=1 for exactly one cycle. in_ready is high in that same cycle, so the minimum gap between frames is one idle cycle.
- ena=0: all registers hold, including tx_out, tx_en and the counters. in_ready=0. done, if pending, is held until ena returns and then lasts one enabled cycle.
- Idle line: tx_out=0, tx_en=0.
- Counters: half-cycle counter is ceil(log2(HALF_CYC))+1 bits wide; bit counter is sized for max(PRE_BITS, DATA_W+1). Neither counter wraps within a frame.

Optional Feature:
MANCH_PARITY_EN: when defined, one extra symbol follows the data, carrying even parity (XOR of all DATA_W bits), encoded with the frame's mode. Frame length grows by one symbol. When undefined, the PAR state and parity logic are absent and the frame ends after the last data bit.

Test Plan:
- DATA_W=8, HALF_CYC=1, PRE_BITS=0, mode=0, msb_first=1, in_data=0xB2 -> tx_out over 16 cycles = 0110_0101_1010_0110 (0x65A6), then done pulse, in_ready=1.
- Same data with mode=1 -> 0x9A59. Then 0xF0 with mode=0 -> 0x55AA, and with mode=1 -> 0xAA55.
- HALF_CYC=2, PRE_BITS=2, mode=0, 0x0F, msb_first=0 -> each half lasts 2 cycles; preamble halves 01 10, then data 1,1,1,1,0,0,0,0; frame is 40 cycles; tx_en high for exactly 40 cycles.
- Back-to-back: in_valid held high with 0xB2 then 0xF0 -> second accept happens in the done cycle, exactly one idle cycle (tx_en=0) between frames; in_ready=0 throughout each frame.
- ena dropped for 5 cycles mid-symbol, then a separate frame with rst_n pulsed low mid-frame -> with ena low, outputs frozen and frame completes 5 cycles late with an identical waveform; on reset, tx_out/tx_en/busy go 0 asynchronously and the next accept starts a fresh frame.
- MANCH_PARITY_EN defined, 0x07, mode=0, msb_first=1 -> 9 symbols; final symbol is parity bit 1, encoded as 01; with 0xB2 the parity symbol is 10.
